// File: rtl/router_pkt_src.sv
// router_pkt_src: builds header + payload + parity packets from a host-loaded buffer for the router input port.
// Optional define PKT_SRC_PARITY_CORRUPT_EN adds a 'corrupt' input that inverts the transmitted parity byte.
module router_pkt_src #(
  parameter int MAX_LEN  = 63,
  parameter int ERR_WAIT = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       buf_we,
  input  logic [5:0] buf_addr,
  input  logic [7:0] buf_wdata,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
`ifdef PKT_SRC_PARITY_CORRUPT_EN
  input  logic       corrupt,
`endif
  output logic       start_ready,
  output logic       bad_req,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  input  logic       busy,
  input  logic       err,
  output logic       done,
  output logic       err_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEND,
    S_PAR,
    S_CHK,
    S_DONE
  } state_t;

  localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);
  localparam logic [5:0] WAIT_LAST = 6'(ERR_WAIT - 1);

  logic [7:0] buf_mem [0:MAX_LEN];

  state_t     state_q, state_d;
  logic [7:0] data_out_q, data_out_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic       done_q, done_d;
  logic       bad_req_q, bad_req_d;
  logic       err_flag_q, err_flag_d;
  logic       start_ready_q, start_ready_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] len_q, len_d;
  logic [7:0] parity_q, parity_d;
  logic       corrupt_q, corrupt_d;

  logic       corrupt_in;
  logic       req_ok;
  logic [5:0] rd_addr;
  logic [7:0] rd_byte;
  logic [7:0] par_next;

`ifdef PKT_SRC_PARITY_CORRUPT_EN
  assign corrupt_in = corrupt;
`else
  assign corrupt_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (buf_we && ({1'b0, buf_addr} <= MAX_LEN_W)) begin
      buf_mem[buf_addr] <= buf_wdata;
    end
  end

  assign req_ok = (dest != 2'd3) && (len != 6'd0) && ({1'b0, len} <= MAX_LEN_W);

  // Next payload byte; a write landing on that entry in the same cycle is forwarded.
  assign rd_addr  = (state_q == S_HDR) ? 6'd0 : (idx_q + 6'd1);
  assign rd_byte  = (buf_we && (buf_addr == rd_addr)) ? buf_wdata : buf_mem[rd_addr];
  assign par_next = parity_q ^ data_out_q;

  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    pkt_valid_d = pkt_valid_q;
    done_d      = 1'b0;
    bad_req_d   = 1'b0;
    err_flag_d  = err_flag_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    parity_d    = parity_q;
    corrupt_d   = corrupt_q;
    case (state_q)
      S_IDLE: begin
        pkt_valid_d = 1'b0;
        data_out_d  = 8'h00;
        if (start) begin
          if (req_ok) begin
            len_d       = len;
            corrupt_d   = corrupt_in;
            err_flag_d  = 1'b0;
            data_out_d  = {len, dest};
            pkt_valid_d = 1'b1;
            state_d     = S_HDR;
          end else begin
            bad_req_d = 1'b1;
          end
        end
      end
      S_HDR: begin
        if (!busy) begin
          parity_d   = data_out_q;
          idx_d      = 6'd0;
          data_out_d = rd_byte;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (!busy) begin
          parity_d = par_next;
          idx_d    = idx_q + 6'd1;
          if (idx_q == len_q - 6'd1) begin
            data_out_d  = corrupt_q ? ~par_next : par_next;
            pkt_valid_d = 1'b0;
            state_d     = S_PAR;
          end else begin
            data_out_d = rd_byte;
          end
        end
      end
      // pkt_valid is low here, so busy cannot stall the parity byte.
      S_PAR: begin
        data_out_d = 8'h00;
        cnt_d      = 6'd0;
        state_d    = S_CHK;
      end
      S_CHK: begin
        err_flag_d = err_flag_q | err;
        if (cnt_q == WAIT_LAST) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    start_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      data_out_q    <= 8'h00;
      pkt_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      bad_req_q     <= 1'b0;
      err_flag_q    <= 1'b0;
      start_ready_q <= 1'b1;
      idx_q         <= 6'd0;
      cnt_q         <= 6'd0;
      len_q         <= 6'd0;
      parity_q      <= 8'h00;
      corrupt_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_out_q    <= data_out_d;
      pkt_valid_q   <= pkt_valid_d;
      done_q        <= done_d;
      bad_req_q     <= bad_req_d;
      err_flag_q    <= err_flag_d;
      start_ready_q <= start_ready_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      parity_q      <= parity_d;
      corrupt_q     <= corrupt_d;
    end
  end

  assign start_ready = start_ready_q;
  assign bad_req     = bad_req_q;
  assign data_out    = data_out_q;
  assign pkt_valid   = pkt_valid_q;
  assign done        = done_q;
  assign err_flag    = err_flag_q;

endmodule
